// File: rtl/neuro_node.sv
// neuro_node: McCulloch-Pitts threshold neuron.
// Two binary excitatory inputs, one absolute inhibitory input and a 2-bit
// threshold. Each valid cycle the decision is registered onto `fire`, and
// a saturating counter tracks how many evaluations fired.
//
// Handshake: in_valid qualifies x, y, inhibit and Threshold in the cycle it
// is high. Each accepted sample produces exactly one out_valid pulse one
// clock later, with no ready/backpressure. The consumer must take `fire`
// and `fire_count` in that out_valid cycle. While in_valid is low, `fire`
// and `fire_count` hold and out_valid stays low.
module neuro_node #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  input  logic             y,
  input  logic             inhibit,
  input  logic [1:0]       Threshold,
  input  logic             in_valid,
  output logic             fire,
  output logic             out_valid,
  output logic [CNT_W-1:0] fire_count
);

  logic [1:0]       sum;
  logic             fire_next;
  logic             fire_q, fire_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] count_q, count_d;

  localparam logic [CNT_W-1:0] CountOne = {{(CNT_W-1){1'b0}}, 1'b1};

  // Combinational decision and next-state computation.
  // The 2-bit sum cannot overflow because its largest value is 2.
  // Threshold is used only in the cycle it is sampled and is never stored.
  always_comb begin
    sum       = {1'b0, x} + {1'b0, y};
    fire_next = (sum >= Threshold) && !inhibit;
    fire_d    = fire_q;
    valid_d   = 1'b0;
    count_d   = count_q;
    if (in_valid) begin
      fire_d  = fire_next;
      valid_d = 1'b1;
      // The counter stops at its all-ones value rather than wrapping.
      if (fire_next && !(&count_q)) begin
        count_d = count_q + CountOne;
      end
    end
  end

  // State registers with asynchronous reset.
  // Reset clears any decision that has not yet been consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fire_q  <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      fire_q  <= fire_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign fire       = fire_q;
  assign out_valid  = valid_q;
  assign fire_count = count_q;

endmodule

// File: tb/tb_neuro_node.sv
// tb_neuro_node: scoreboard bench for neuro_node.
// The bench instantiates two copies of the design, one with an 8-bit counter
// and one with a 2-bit counter. The 2-bit copy exercises saturation quickly.
module tb_neuro_node;

  localparam int W = 11; // {fire, count8[7:0], count2[1:0]}

  logic       clk = 1'b0;
  logic       rst;
  logic       x, y, inhibit, in_valid;
  logic [1:0] thr;
  logic       fire8, ov8, fire2, ov2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  logic [W-1:0] exp_q[$];

  // Model state: counts held as plain integers.
  int  m8 = 0;
  int  m2 = 0;
  // Last output values that were consumed; outputs must hold these when idle.
  logic       last_fire = 1'b0;
  logic [7:0] last_c8   = '0;
  logic [1:0] last_c2   = '0;

  neuro_node #(.CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .x(x), .y(y), .inhibit(inhibit),
    .Threshold(thr), .in_valid(in_valid),
    .fire(fire8), .out_valid(ov8), .fire_count(cnt8)
  );

  neuro_node #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .x(x), .y(y), .inhibit(inhibit),
    .Threshold(thr), .in_valid(in_valid),
    .fire(fire2), .out_valid(ov2), .fire_count(cnt2)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Driver: apply one cycle of inputs. A valid sample updates the model and
  // pushes the expected response.
  task automatic drive(input logic xv, input logic yv, input logic iv,
                       input logic [1:0] tv, input logic vv);
    logic f;
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    x = xv; y = yv; inhibit = iv; thr = tv; in_valid = vv;
    if (vv) begin
      f = ((int'(xv) + int'(yv)) >= int'(tv)) && !iv;
      if (f) begin
        if (m8 < 255) m8 = m8 + 1;
        if (m2 < 3)   m2 = m2 + 1;
      end
      e = {f, m8[7:0], m2[1:0]};
      exp_q.push_back(e);
    end
  endtask

  // Assert reset mid-cycle, check that outputs clear immediately, and drop
  // any in-flight expectation.
  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("rst_fire8", fire8, 1'b0);
    check("rst_ov8",   ov8,   1'b0);
    check("rst_cnt8",  cnt8,  8'd0);
    check("rst_fire2", fire2, 1'b0);
    check("rst_ov2",   ov2,   1'b0);
    check("rst_cnt2",  cnt2,  2'd0);
    exp_q.delete();
    m8 = 0; m2 = 0;
    last_fire = 1'b0; last_c8 = '0; last_c2 = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Monitor: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst) begin
      if (ov8 || ov2) begin
        check("ov8", ov8, 1'b1);
        check("ov2", ov2, 1'b1);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("fire8", fire8, e[10]);
          check("fire2", fire2, e[10]);
          check("cnt8",  cnt8,  e[9:2]);
          check("cnt2",  cnt2,  e[1:0]);
          last_fire = e[10];
          last_c8   = e[9:2];
          last_c2   = e[1:0];
        end
      end else begin
        check("hold_fire8", fire8, last_fire);
        check("hold_fire2", fire2, last_fire);
        check("hold_cnt8",  cnt8,  last_c8);
        check("hold_cnt2",  cnt2,  last_c2);
      end
    end
  end

  initial begin
    rst = 1'b1;
    x = 1'b0; y = 1'b0; inhibit = 1'b0; thr = 2'd0; in_valid = 1'b0;
    #3;
    check("init_fire8", fire8, 1'b0);
    check("init_ov8",   ov8,   1'b0);
    check("init_cnt8",  cnt8,  8'd0);
    check("init_cnt2",  cnt2,  2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Threshold 2: AND behaviour
    drive(0, 0, 0, 2'd2, 1);
    drive(0, 1, 0, 2'd2, 1);
    drive(1, 0, 0, 2'd2, 1);
    drive(1, 1, 0, 2'd2, 1);
    // Threshold 1: OR behaviour
    drive(0, 0, 0, 2'd1, 1);
    drive(0, 1, 0, 2'd1, 1);
    drive(1, 0, 0, 2'd1, 1);
    drive(1, 1, 0, 2'd1, 1);
    // Threshold extremes
    drive(0, 0, 0, 2'd0, 1);
    drive(1, 1, 0, 2'd3, 1);
    // Inhibit dominates
    drive(1, 1, 1, 2'd1, 1);
    drive(1, 1, 0, 2'd1, 1);
    drive(0, 0, 1, 2'd0, 1);
    drive(0, 0, 0, 2'd0, 0);

    // Reset with a decision in flight
    drive(1, 1, 0, 2'd0, 1);
    do_reset();

    // Five firing evaluations; the 2-bit counter must stop at 3
    for (int i = 0; i < 5; i++) drive(1'(i), 0, 0, 2'd0, 1);

    // Fire, then toggle inputs while idle; outputs must hold
    drive(1, 1, 0, 2'd2, 1);
    for (int i = 0; i < 6; i++)
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 0);

    // Randomized traffic with idle cycles and occasional resets
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
              1'($urandom_range(0, 3) != 0));
      end
    end

    // Drain with a bounded wait
    drive(0, 0, 0, 2'd0, 0);
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
